// File: rtl/uart_tx.sv
// UART transmitter: 8N1 frames with optional parity, LSB first.
// Bit timing comes from an internal divide-by-CLKS_PER_BIT cycle counter.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          r_state, w_state_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic [2:0]      r_bit, w_bit_n;
  logic [7:0]      r_shift, w_shift_n;
  logic            r_par, w_par_n;
  logic            r_tx, w_tx_n;
  logic            r_ready, w_ready_n;
  logic            r_done, w_done_n;
  logic            w_bit_end;

  assign w_bit_end = (r_cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_par   <= w_par_n;
      r_tx    <= w_tx_n;
      r_ready <= w_ready_n;
      r_done  <= w_done_n;
    end
  end

  // tx is registered, so each transition loads the line value of the bit being entered
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_par_n   = r_par;
    w_tx_n    = r_tx;
    w_ready_n = r_ready;
    w_done_n  = 1'b0;

    case (r_state)
      IDLE: begin
        w_tx_n    = 1'b1;
        w_ready_n = 1'b1;
        if (tx_valid && r_ready) begin
          w_shift_n = tx_data;
          w_par_n   = PARITY_ODD ? ~^tx_data : ^tx_data;
          w_ready_n = 1'b0;
          w_tx_n    = 1'b0;
          w_cnt_n   = '0;
          w_bit_n   = '0;
          w_state_n = START;
        end
      end

      START: begin
        w_cnt_n = r_cnt + 1'b1;
        if (w_bit_end) begin
          w_cnt_n   = '0;
          w_tx_n    = r_shift[0];
          w_state_n = DATA;
        end
      end

      DATA: begin
        w_cnt_n = r_cnt + 1'b1;
        if (w_bit_end) begin
          w_cnt_n   = '0;
          w_shift_n = {1'b0, r_shift[7:1]};
          w_bit_n   = r_bit + 1'b1;
          w_tx_n    = r_shift[1];
          if (r_bit == 3'd7) begin
            w_bit_n = '0;
            if (PARITY_EN) begin
              w_tx_n    = r_par;
              w_state_n = PARITY;
            end else begin
              w_tx_n    = 1'b1;
              w_state_n = STOP;
            end
          end
        end
      end

      PARITY: begin
        w_cnt_n = r_cnt + 1'b1;
        if (w_bit_end) begin
          w_cnt_n   = '0;
          w_tx_n    = 1'b1;
          w_state_n = STOP;
        end
      end

      STOP: begin
        w_cnt_n = r_cnt + 1'b1;
        if (w_bit_end) begin
          w_cnt_n   = '0;
          w_tx_n    = 1'b1;
          w_ready_n = 1'b1;
          w_done_n  = 1'b1;
          w_state_n = IDLE;
        end
      end

      default: begin
        w_tx_n    = 1'b1;
        w_cnt_n   = '0;
        w_state_n = IDLE;
      end
    endcase
  end

  assign tx       = r_tx;
  assign tx_ready = r_ready;
  assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one no-parity, one even-parity and one odd-parity
// instance, all at 4 clocks per bit, driven one at a time through a shared mux.
module tb_uart_tx;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tbValid = 1'b0;
  logic [7:0] tbData = 8'h00;
  int         sel = 0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         lastA = 0;

  logic v0, vE, vO;
  logic r0, rE, rO;
  logic t0, tE, tO;
  logic d0, dE, dO;
  logic lineTx, lineReady, lineDone;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign v0 = (sel == 0) && tbValid;
  assign vE = (sel == 1) && tbValid;
  assign vO = (sel == 2) && tbValid;

  always_comb begin
    lineTx = t0; lineReady = r0; lineDone = d0;
    if (sel == 1) begin
      lineTx = tE; lineReady = rE; lineDone = dE;
    end else if (sel == 2) begin
      lineTx = tO; lineReady = rO; lineDone = dO;
    end
  end

  uart_tx #(.CLKS_PER_BIT(N), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .tx_valid(v0), .tx_data(tbData),
    .tx_ready(r0), .tx(t0), .tx_done(d0));

  uart_tx #(.CLKS_PER_BIT(N), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dutE (
    .clk(clk), .rst(rst), .tx_valid(vE), .tx_data(tbData),
    .tx_ready(rE), .tx(tE), .tx_done(dE));

  uart_tx #(.CLKS_PER_BIT(N), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dutO (
    .clk(clk), .rst(rst), .tx_valid(vO), .tx_data(tbData),
    .tx_ready(rO), .tx(tO), .tx_done(dO));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic frameBit(input int idx, input logic [7:0] b,
                                    input bit withPar, input logic parBit);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (idx == 9 && withPar) return parBit;
    return 1'b1;
  endfunction

  // Sends one byte on the selected instance and checks the line every cycle.
  // abortAt >= 0 pulses reset at that cycle offset from acceptance instead.
  task automatic applyStimulus(input logic [7:0] b, input bit withPar, input logic parBit,
                               input bit holdValid, input logic [7:0] nextData,
                               input bit noise, input int abortAt);
    int nb;
    int t;
    nb = withPar ? 11 : 10;
    t = 0;
    while (!lineReady && t < 100) begin
      @(negedge clk);
      t++;
    end
    checkOutput("readyBeforeSend", 32'(lineReady), 32'd1);
    tbValid = 1'b1;
    tbData  = b;
    @(posedge clk);
    @(negedge clk);
    lastA   = cyc;
    tbValid = holdValid;
    tbData  = holdValid ? nextData : 8'h00;
    for (int k = 0; k < nb * N; k++) begin
      if (k > 0) @(negedge clk);
      if (noise) begin
        tbValid = (k < nb * N - 1) ? k[0] : 1'b0;
        tbData  = k[0] ? 8'hFF : 8'(k * 29);
      end
      checkOutput("txBit", 32'(lineTx), 32'(frameBit(k / N, b, withPar, parBit)));
      if (k == abortAt) begin
        #2 rst = 1'b1;
        #1;
        checkOutput("abortTxHigh", 32'(lineTx), 32'd1);
        checkOutput("abortReadyLow", 32'(lineReady), 32'd0);
        repeat (3) begin
          @(negedge clk);
          checkOutput("abortNoDone", 32'(lineDone), 32'd0);
          checkOutput("abortTxIdle", 32'(lineTx), 32'd1);
        end
        #2 rst = 1'b0;
        tbValid = 1'b0;
        return;
      end
      if (k == nb * N - 1) checkOutput("doneEarly", 32'(lineDone), 32'd0);
    end
    @(negedge clk);
    checkOutput("doneAtEnd", 32'(lineDone), 32'd1);
    checkOutput("readyAtEnd", 32'(lineReady), 32'd1);
    checkOutput("doneLatency", 32'(cyc - lastA), 32'(nb * N));
    if (!holdValid) begin
      @(negedge clk);
      checkOutput("donePulseWidth", 32'(lineDone), 32'd0);
      checkOutput("idleTx", 32'(lineTx), 32'd1);
    end
  endtask

  initial begin
    int firstA;

    // reset held for three cycles
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("rstTx", 32'(t0), 32'd1);
      checkOutput("rstDone", 32'(d0), 32'd0);
      checkOutput("rstReady", 32'(r0), 32'd0);
      checkOutput("rstTxParity", 32'({tE, tO}), 32'h3);
    end
    #2 rst = 1'b0;
    #1 checkOutput("readyBeforeEdge", 32'(r0), 32'd0);
    @(negedge clk);
    checkOutput("readyAfterEdge", 32'(r0), 32'd1);
    checkOutput("txAfterRelease", 32'(t0), 32'd1);
    checkOutput("doneAfterRelease", 32'(d0), 32'd0);

    sel = 0;
    applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, -1);

    // streaming: valid held across two frames
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, -1);
    firstA = lastA;
    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, -1);
    checkOutput("streamSpacing", 32'(lastA - firstA), 32'd41);

    // busy: valid and data toggle during the frame
    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, -1);
    repeat (8) begin
      @(negedge clk);
      checkOutput("noSpuriousFrame", 32'(lineTx), 32'd1);
    end

    // parity: 0x07 has three ones
    sel = 1;
    applyStimulus(8'h07, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, -1);
    sel = 2;
    applyStimulus(8'h07, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, -1);

    // reset during data bit 3, then a clean frame
    sel = 0;
    applyStimulus(8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4 * N + 1);
    applyStimulus(8'h81, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter: accepts an 8-bit byte over a valid/ready handshake and serialises it onto a single line. The frame is 1 start bit, 8 data bits LSB first, an optional parity bit and 1 stop bit. It pairs with the receiver path's serial-in/parallel-out register. LSB-first ordering matches that register, which shifts right and loads new bits at bit 7. Bit timing comes from an internal divide-by-CLKS_PER_BIT counter, so no external baud tick is needed.

## Interface
- CLKS_PER_BIT, 16: clk cycles per serial bit; legal range ≥ 2.
- PARITY_EN, 0: 1 inserts a parity bit after data bit 7.
- PARITY_ODD, 0: with PARITY_EN=1, 0 selects even parity and 1 selects odd parity.

- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- tx_valid  input  1  byte on tx_data is offered for transmission.
- tx_data  input  8  byte to send; sampled only on the acceptance edge.
- tx_ready  output  1  block can accept a byte (registered).
- tx  output  1  serial line; idles high (registered).
- tx_done  output  1  one-cycle pulse when the stop bit completes (registered).

## Operation
- **Reset values** (rst high): tx=1, tx_ready=0, tx_done=0, state=IDLE, bit counter=0, cycle counter=0, shift register=0.
- **After reset release:** tx_ready rises on the first rising clk edge.
- **States:** IDLE → START → DATA → (PARITY if PARITY_EN) → STOP → IDLE.
- **IDLE:** tx=1, tx_ready=1.
  - Acceptance is tx_valid && tx_ready at a rising edge.
  - On acceptance: tx_data is loaded into the shift register, parity is computed from tx_data, tx_ready←0, tx←0, state←START, cycle counter←0.
- **Bit timing:** every non-IDLE state holds tx for exactly CLKS_PER_BIT cycles.
  - The cycle counter runs 0..CLKS_PER_BIT-1.
  - At the edge where the counter equals CLKS_PER_BIT-1: advance to the next bit/state and clear the counter.
- **DATA:** tx = shift register bit 0. At each bit boundary, shift right by one and increment the bit counter. After bit 7 completes, go to PARITY or STOP.
- **PARITY:** tx = ^data for even parity, ~^data for odd parity. The total number of ones across data plus parity is even (even mode) or odd (odd mode).
- **STOP:** tx=1. On the final stop cycle edge: state←IDLE, tx_ready←1, tx_done←1 for one cycle.
- **Handshake rules:**
  - tx_valid while tx_ready=0 is ignored; nothing is queued.
  - Changes to tx_data after acceptance have no effect on the frame in flight.
  - tx_valid may be held high continuously to stream bytes.
- **Reset mid-frame:** the frame is aborted at once, tx returns high asynchronously, and no tx_done is produced.
- **Counter widths:**
  - Cycle counter: $clog2(CLKS_PER_BIT) bits.
  - Bit counter: 3 bits.
  - Neither counter may wrap inside a bit; compare against CLKS_PER_BIT-1 and 7 explicitly.

## Timing
Let A be the acceptance edge and N = CLKS_PER_BIT.
- **Latency:** tx falls on edge A, i.e. the start bit is visible in the cycle after A.
- **Start bit:** edges A .. A+N.
- **Data bit i** (i = 0..7): edges A+(1+i)N .. A+(2+i)N.
- **Parity** (if enabled): edges A+9N .. A+10N.
- **Stop bit:** occupies the next N cycles.
- **End of frame:** at edge E = A+10N (A+11N with parity), tx_ready and tx_done rise together.
- **tx_done** is high for exactly one cycle.
- **Back-to-back frames:** with tx_valid held high, the next acceptance is at E+1. The line stays high for N+1 cycles between start bits, and the frame period is 10N+1 (11N+1 with parity) cycles.
- **Throughput:** one byte per frame; no buffering beyond the single shift register.

## Test plan
- **Reset values:** assert rst for 3 cycles, then release. tx=1 and tx_done=0 throughout; tx_ready=0 during reset and 1 one edge after release.
- **Single byte, no parity:** N=4, send 0xA5. tx sequence, each bit 4 cycles: 0, 1,0,1,0,0,1,0,1, 1. tx_done pulses at A+40; tx_ready returns at the same edge.
- **Streaming:** N=4, hold tx_valid with 0x00 then 0xFF.
  - Second acceptance at A+41.
  - Data of the first frame is all 0; data of the second frame is all 1.
  - Stop and idle high for exactly 5 cycles between frames.
- **Busy/hold:** during a 0x3C frame, pulse tx_valid with 0xFF and change tx_data each cycle. The line still carries 0x3C, and no second frame starts without a new handshake.
- **Parity:** PARITY_EN=1, send 0x07.
  - PARITY_ODD=0: parity bit 1.
  - PARITY_ODD=1: parity bit 0.
  - tx_done occurs at A+44 for N=4.
- **Reset mid-frame:** assert rst during data bit 3. tx goes high immediately, with no tx_done. After release, a new 0x81 frame transmits correctly.
